// File: rtl/music_pkg.sv
// Pattern-word layout and sequencer state encoding shared by the
// note sequencer and anything that builds pattern ROM images.
package music_pkg;

  localparam int WORD_W    = 16;
  localparam int PITCH_LSB = 0;
  localparam int PITCH_W   = 6;
  localparam int DUR_LSB   = 6;
  localparam int DUR_W     = 5;
  localparam int INST_LSB  = 11;
  localparam int INST_W    = 4;
  localparam int END_BIT   = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_PLAY
  } seq_state_e;

  function automatic logic [PITCH_W-1:0] pitch_of(
    input logic [WORD_W-1:0] w
  );
    return w[PITCH_LSB +: PITCH_W];
  endfunction

  function automatic logic [DUR_W-1:0] dur_of(
    input logic [WORD_W-1:0] w
  );
    return w[DUR_LSB +: DUR_W];
  endfunction

  function automatic logic [INST_W-1:0] inst_of(
    input logic [WORD_W-1:0] w
  );
    return w[INST_LSB +: INST_W];
  endfunction

endpackage

// File: rtl/note_sequencer.sv
// Walks a pattern ROM and feeds one note_player voice, prefetching
// the next word while the current note plays.
module note_sequencer
  import music_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic              i_done,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [WORD_W-1:0] i_rom_data,
  output logic              o_load,
  output logic [PITCH_W-1:0] o_pitch,
  output logic [DUR_W-1:0]  o_duration,
  output logic [INST_W-1:0] o_instrument,
  output logic              o_busy,
  output logic              o_finished
);

  seq_state_e        state;
  logic [ADDR_W-1:0] start_q;
  logic [WORD_W-1:0] next_q;
  logic              nv;
  logic              pend;
  logic              phase;
  logic              go;

  // a done that arrived before the prefetch landed is acted on later
  assign go     = nv && (i_done || pend);
  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      start_q      <= '0;
      next_q       <= '0;
      nv           <= 1'b0;
      pend         <= 1'b0;
      phase        <= 1'b0;
      o_rom_addr   <= '0;
      o_load       <= 1'b0;
      o_finished   <= 1'b0;
      o_pitch      <= '0;
      o_duration   <= '0;
      o_instrument <= '0;
    end else begin
      o_load     <= 1'b0;
      o_finished <= 1'b0;
      if (i_stop) begin
        state <= S_IDLE;
        nv    <= 1'b0;
        pend  <= 1'b0;
        phase <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (i_start) begin
              start_q    <= i_start_addr;
              o_rom_addr <= i_start_addr;
              state      <= S_FETCH;
            end
          end
          S_FETCH: state <= S_DECODE;
          S_DECODE: begin
            if (i_rom_data[END_BIT]) begin
              if (i_loop) begin
                o_rom_addr <= start_q;
                state      <= S_FETCH;
              end else begin
                o_finished <= 1'b1;
                state      <= S_IDLE;
              end
            end else begin
              o_pitch      <= pitch_of(i_rom_data);
              o_duration   <= dur_of(i_rom_data);
              o_instrument <= inst_of(i_rom_data);
              o_load       <= 1'b1;
              state        <= S_LOAD;
            end
          end
          S_LOAD: begin
            o_rom_addr <= o_rom_addr + 1'b1;
            nv         <= 1'b0;
            pend       <= 1'b0;
            phase      <= 1'b0;
            state      <= S_PLAY;
          end
          S_PLAY: begin
            if (!phase) begin
              phase <= 1'b1;
            end else if (!nv) begin
              next_q <= i_rom_data;
              nv     <= 1'b1;
            end
            if (i_done && !nv) begin
              pend <= 1'b1;
            end
            if (go) begin
              nv   <= 1'b0;
              pend <= 1'b0;
              if (next_q[END_BIT]) begin
                if (i_loop) begin
                  o_rom_addr <= start_q;
                  state      <= S_FETCH;
                end else begin
                  o_finished <= 1'b1;
                  state      <= S_IDLE;
                end
              end else begin
                o_pitch      <= pitch_of(next_q);
                o_duration   <= dur_of(next_q);
                o_instrument <= inst_of(next_q);
                o_load       <= 1'b1;
                state        <= S_LOAD;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Pattern controller that sequences one note_player voice.
- Walks a 16-bit pattern ROM through a synchronous ROM port with 1-cycle read latency.
- Decodes each word into pitch, duration and instrument, and issues a one-cycle load to the player.
- Prefetches the next word while the current note plays, so the next load follows the player's done pulse in one cycle. Handles end-of-pattern markers with optional looping.

Parameters:
- ADDR_W, 8, pattern ROM address width; the address wraps modulo 2^ADDR_W.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  pulse; start the pattern at i_start_addr (honoured only in IDLE)
- i_stop  in  1  pulse; abort playback, return to IDLE
- i_loop  in  1  level; sampled at an END word: 1 = restart at the latched start address, 0 = finish
- i_start_addr  in  ADDR_W  first word of the pattern
- i_done  in  1  note_player done pulse, one cycle
- o_rom_addr  out  ADDR_W  registered ROM address
- i_rom_data  in  16  ROM word, valid the cycle after o_rom_addr changes
- o_load  out  1  one-cycle load strobe to note_player
- o_pitch  out  6  registered; o_pitch = word[5:0]
- o_duration  out  5  registered; o_duration = word[10:6]
- o_instrument  out  4  registered; o_instrument = word[14:11]
- o_busy  out  1  high in every state except IDLE
- o_finished  out  1  one-cycle pulse when a non-looping pattern reaches END

Behaviour:
- Clock and reset: one clock domain (i_clk). Reset is synchronous and active-high (i_rst).
- Word format:
  - bit15 = END. An END word is never loaded into the player.
  - bits14:0 = instrument/duration/pitch, as listed in Ports.
- Reset values:
  - state = IDLE; o_load = o_busy = o_finished = 0.
  - o_pitch, o_duration, o_instrument = 0; o_rom_addr = 0.
  - Start-address register = 0; next-word valid flag r_nv = 0.
- States: IDLE, FETCH, DECODE, LOAD, PLAY.
- IDLE:
  - On i_start: latch i_start_addr into the start register and into o_rom_addr, then go to FETCH.
- FETCH:
  - Address is on the bus for one cycle; go to DECODE.
- DECODE:
  - i_rom_data is valid in this cycle.
  - If END with i_loop = 1: set o_rom_addr to the start register and go to FETCH.
  - If END with i_loop = 0: pulse o_finished next cycle and go to IDLE.
  - If END is reached with no note played since start, the same rules apply (an empty pattern just finishes or spins).
  - Otherwise: register the fields, go to LOAD.
- LOAD:
  - o_load = 1 for exactly this cycle.
  - o_rom_addr increments by 1 (wraps); go to PLAY.
- PLAY (prefetch):
  - 1st cycle: address presented.
  - 2nd cycle: capture i_rom_data into r_next and set r_nv = 1.
  - On i_done with r_nv = 1 and r_next not END: copy r_next to the outputs, clear r_nv, go to LOAD.
  - On i_done with r_nv = 1 and r_next END: apply the same END rules as DECODE, using i_loop as sampled at that cycle.
  - On i_done with r_nv = 0: hold a pending-done flag and act as soon as r_nv sets.
  - i_done outside PLAY is ignored.
- Latency: i_start sampled at edge N gives o_load high in cycle N+3. A done-to-next-load gap is 1 cycle.
- i_stop:
  - In any state, next state is IDLE.
  - o_load is forced low that cycle; r_nv and the pending flag clear; o_finished is not asserted.
  - i_stop beats i_start in the same cycle.
- i_start while busy: ignored.
- i_rst mid-playback: identical to the reset values, with no o_load or o_finished pulse.
- Output holding: o_pitch, o_duration and o_instrument hold their last values between loads and after stop.

Decomposition:
- Shared package (music_pkg):
  - Pattern-word field offsets and widths: PITCH_LSB=0/W=6, DUR_LSB=6/W=5, INST_LSB=11/W=4, END_BIT=15.
  - State enum for the sequencer.
- Sub-module: none needed.
- The bench wraps note_sequencer with rom_sync_fake (WIDTH 16) and, where required, note_player.

Test Plan:
- ROM[0x10]=0x0123, ROM[0x11]=0x8000; i_start_addr=0x10, i_loop=0, i_start at cycle 0 → o_load at cycle 3 with pitch=0x23, dur=0x04, inst=0x0. After i_done, o_finished pulses once, then o_busy=0, with no second o_load.
- Three notes then END, i_done 20 cycles after each load → exactly 3 o_load pulses, each one cycle after the preceding i_done, with fields matching ROM.
- Same pattern with i_loop=1 → after note 3's i_done, o_rom_addr returns to 0x10 and note 1 reloads. o_finished is never asserted.
- i_stop during PLAY, and i_stop+i_start in the same cycle → IDLE next cycle, o_busy=0, no o_load or o_finished. A later i_start restarts at the new i_start_addr.
- i_start_addr=0xFF, ROM[0xFF] a note, ROM[0x00]=END → prefetch address wraps to 0x00, and the sequence ends normally.
- i_rst asserted in PLAY, and i_done pulsed in IDLE → all outputs return to their reset values; stray i_done causes no activity.
